ps2_host_tx: RTL



---
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_host_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the game-side controller and the PS/2 host transmitter.
// The controller takes the master side; the transmitter takes the slave side.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, busy, done, err
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, busy, done, err
   );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard over the
// open-drain PS2_CLK/PS2_DATA pair and reports ACK, NACK or timeout.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int SETUP_CYCLES   = 500,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int FILTER_LEN     = 8
) (
   input  logic          clk,
   input  logic          rst,
   ps2_host_tx_if.slave  host,
   input  logic          ps2_clk_in,
   input  logic          ps2_data_in,
   output logic          ps2_clk_oe,
   output logic          ps2_data_oe
);

   localparam int MAX_PHASE = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
   localparam int MAX_CNT   = (TIMEOUT_CYCLES > MAX_PHASE) ? TIMEOUT_CYCLES : MAX_PHASE;
   localparam int TIMER_W   = $clog2(MAX_CNT + 1);
   localparam int FILT_W    = $clog2(FILTER_LEN + 1);

   localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SETUP_LAST   = TIMER_W'(SETUP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FILT_W-1:0]  FILT_LAST    = FILT_W'(FILTER_LEN - 1);
   localparam logic [3:0]         ACK_BIT      = 4'd10;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      WAIT_IDLE
   } state_e;

   // ---------------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------------
   logic clk_meta_q, clk_sync_q;
   logic data_meta_q, data_sync_q;
   logic filt_q, filt_d;
   logic filt_prev_q;
   logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
   logic fall;

   // NOTE: synchronizer and filter flops reset to the idle-high line level so that
   // leaving reset never looks like a clock edge to the shifter.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         filt_cnt_q  <= '0;
      end else begin
         clk_meta_q  <= ps2_clk_in;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= ps2_data_in;
         data_sync_q <= data_meta_q;
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         filt_cnt_q  <= filt_cnt_d;
      end
   end

   // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (clk_sync_q != filt_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            filt_d = clk_sync_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   assign fall = filt_prev_q & ~filt_q;

   // ---------------------------------------------------------------------------
   // Transfer FSM
   // ---------------------------------------------------------------------------
   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [9:0]           frame_q, frame_d;
   logic                 clk_oe_q, clk_oe_d;
   logic                 data_oe_q, data_oe_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 timeout;

   assign timeout = (timer_q == TIMEOUT_LAST);

   // NOTE: every output of this block gets a default first, so no path can leave a
   // variable unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_cnt_d = bit_cnt_q;
      frame_d   = frame_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (host.tx_valid) begin
               frame_d   = {1'b1, ~^host.tx_data, host.tx_data};
               bit_cnt_d = '0;
               timer_d   = '0;
               clk_oe_d  = 1'b1;
               state_d   = INHIBIT;
            end
         end

         INHIBIT: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == INHIBIT_LAST) begin
               timer_d   = '0;
               data_oe_d = 1'b1;
               state_d   = REQ;
            end
         end

         REQ: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == SETUP_LAST) begin
               timer_d  = '0;
               clk_oe_d = 1'b0;
               state_d  = SHIFT;
            end
         end

         // Frame bits shift out LSB first; the stop bit (1) releases the data line.
         SHIFT: begin
            timer_d = timer_q + 1'b1;
            if (timeout) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               err_d     = 1'b1;
               state_d   = IDLE;
            end else if (fall) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == ACK_BIT) begin
                  data_oe_d = 1'b0;
                  if (data_sync_q) begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = WAIT_IDLE;
                  end
               end else begin
                  data_oe_d = ~frame_q[0];
                  frame_d   = {1'b1, frame_q[9:1]};
               end
            end
         end

         WAIT_IDLE: begin
            timer_d = timer_q + 1'b1;
            if (timeout) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               err_d     = 1'b1;
               state_d   = IDLE;
            end else if (filt_q && data_sync_q) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               done_d    = 1'b1;
               state_d   = IDLE;
            end
         end

         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the values
   // from before this edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         frame_q   <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         frame_q   <= frame_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign host.tx_ready = (state_q == IDLE);
   assign host.busy     = (state_q != IDLE);
   assign host.done     = done_q;
   assign host.err      = err_q;
   assign ps2_clk_oe    = clk_oe_q;
   assign ps2_data_oe   = data_oe_q;

endmodule
